// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: bus widths, AXI response codes and arbiter FSM states shared by the master arbiter
package axi4lite_pkg;
  localparam int ADDRWIDTH = 32;
  localparam int DATAWIDTH = 32;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_t;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or after the pointer; pointer moves past the winner on advance
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] w_rot;
  logic [PW-1:0]   w_off;
  logic [PW:0]     w_sum;
  // rotate requests so the pointer sits at bit 0, then take the lowest set bit
  always_comb begin
    w_rot = NREQ'({i_req, i_req} >> r_ptr);
    w_off = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (w_rot[j]) w_off = PW'(j);
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    o_idx = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
    o_any = |i_req;
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end
  // pointer moves to the requester just after the winner, wrapping
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (i_advance && o_any) r_ptr <= (o_idx == PW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
  end
endmodule

// File: rtl/axi4lite_master_arbiter.sv
// axi4lite_master_arbiter: round-robin sharing of one AXI4-lite master port, one transaction at a time.
// Optional AXI_TIMEOUT_EN: abort any AXI wait state after TIMEOUT_CYCLES cycles with an error response.
module axi4lite_master_arbiter
  import axi4lite_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ-1:0][ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ-1:0][DATAWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [DATAWIDTH-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDRWIDTH-1:0]           AWADDR,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [DATAWIDTH-1:0]           WDATA,
  output logic                           WVALID,
  input  logic                           WREADY,
  input  logic [1:0]                     BRESP,
  input  logic                           BVALID,
  output logic                           BREADY,
  output logic [ADDRWIDTH-1:0]           ARADDR,
  output logic                           ARVALID,
  input  logic                           ARREADY,
  input  logic [DATAWIDTH-1:0]           RDATA,
  input  logic [1:0]                     RRESP,
  input  logic                           RVALID,
  output logic                           RREADY
);
  localparam int PW = $clog2(NREQ);
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("axi4lite_master_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end
  arb_state_t           r_state;
  logic [PW-1:0]        r_g;
  logic [ADDRWIDTH-1:0] r_awaddr, r_araddr;
  logic [DATAWIDTH-1:0] r_wdata, r_rdata, r_rsp_rdata;
  logic                 r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_rsp_err;
  logic [NREQ-1:0]      r_rsp_valid;
  resp_t                r_resp;
  logic [NREQ-1:0]      w_grant;
  logic [PW-1:0]        w_idx;
  logic                 w_any, w_idle, w_step, w_tmo;
  assign w_idle = r_state == S_IDLE;
  // w_step: the current wait state finishes normally this cycle
  assign w_step = (r_state == S_WR && (!r_awvalid || AWREADY) && (!r_wvalid || WREADY)) ||
                  (r_state == S_WR_RESP && BVALID) ||
                  (r_state == S_RD_ADDR && ARREADY) ||
                  (r_state == S_RD_DATA && RVALID);
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_advance (w_idle),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );
  assign req_ready = w_idle ? w_grant : '0;
`ifdef AXI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait;
  logic          w_wait_st;
  assign w_wait_st = r_state inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA};
  assign w_tmo = w_wait_st && r_wait == TW'(TIMEOUT_CYCLES - 1);
  // wait counter restarts on every state entry and runs only inside AXI wait states
  always_ff @(posedge clk) begin
    r_wait <= (rst || !w_wait_st || w_step || w_tmo) ? '0 : r_wait + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif
  // transaction sequencer: grant, AXI channel handshakes, response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_g       <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_araddr  <= '0;
      r_resp    <= OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_g       <= w_idx;
          r_state   <= req_we[w_idx] ? S_WR : S_RD_ADDR;
          r_awvalid <= req_we[w_idx];
          r_wvalid  <= req_we[w_idx];
          r_arvalid <= !req_we[w_idx];
          if (req_we[w_idx]) begin
            r_awaddr <= req_addr[w_idx];
            r_wdata  <= req_wdata[w_idx];
          end else r_araddr <= req_addr[w_idx];
        end
        S_WR: begin
          if (AWREADY) r_awvalid <= 1'b0;
          if (WREADY) r_wvalid <= 1'b0;
          if (w_step) begin
            r_state  <= S_WR_RESP;
            r_bready <= 1'b1;
          end
        end
        S_WR_RESP: if (w_step) begin
          r_bready <= 1'b0;
          r_resp   <= resp_t'(BRESP);
          r_rdata  <= '0;
          r_state  <= S_RSP;
        end
        S_RD_ADDR: if (w_step) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_RD_DATA;
        end
        S_RD_DATA: if (w_step) begin
          r_rready <= 1'b0;
          r_rdata  <= RDATA;
          r_resp   <= resp_t'(RRESP);
          r_state  <= S_RSP;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_tmo) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_resp    <= SLVERR;
        r_rdata   <= '0;
        r_state   <= S_RSP;
      end
    end
  end
  // response pulse to the winner, presented in the cycle the sequencer is back in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (r_state == S_RSP) ? (NREQ'(1) << r_g) : '0;
      if (r_state == S_RSP) begin
        r_rsp_err   <= r_resp != OKAY;
        r_rsp_rdata <= r_rdata;
      end
    end
  end
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_araddr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;
endmodule
